board_ansi_streamer: RTL



---
 rtl/board_ansi_streamer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/board_ansi_streamer.sv
// Board-to-terminal streamer: snapshots the Game-of-Life board on start and
// emits one ANSI frame (cursor-home, one byte per cell, CR LF per row) over a
// byte-wide valid/ready stream. All outputs are registered.
module board_ansi_streamer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HEIGHT     = 8,
  parameter logic [7:0]  ALIVE_CHAR = 8'h4F,
  parameter logic [7:0]  DEAD_CHAR  = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   board,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int unsigned NCells = WIDTH * HEIGHT;
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam int unsigned RW     = $clog2(HEIGHT);
  localparam int unsigned IW     = $clog2(NCells);

  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StHome, StCell, StCr, StLf} state_e;

  state_e            state_q;
  logic [NCells-1:0] snap_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [IW-1:0]     idx_q;   // linear cell index, tracks row*WIDTH+col
  logic [1:0]        home_q;
  logic              xfer;
  logic [IW-1:0]     idx_nxt;

  function automatic logic [7:0] home_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h1B;
      2'd1:    return 8'h5B;
      2'd2:    return 8'h3B;
      default: return 8'h48;
    endcase
  endfunction

  function automatic logic [7:0] cell_char(input logic alive);
    return alive ? ALIVE_CHAR : DEAD_CHAR;
  endfunction

  // Transfer handshake and the index of the cell following the current one.
  assign xfer    = tx_valid & tx_ready;
  assign idx_nxt = idx_q + IW'(1);

  // Frame sequencer; tx_data is preloaded with the next byte on each transfer
  // so the stream runs without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      idx_q    <= '0;
      home_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            snap_q   <= board;
            state_q  <= StHome;
            home_q   <= 2'd0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= home_byte(2'd0);
          end
        end
        StHome: begin
          if (xfer) begin
            if (home_q == 2'd3) begin
              state_q <= StCell;
              row_q   <= '0;
              col_q   <= '0;
              idx_q   <= '0;
              tx_data <= cell_char(snap_q[0]);
            end else begin
              home_q  <= home_q + 2'd1;
              tx_data <= home_byte(home_q + 2'd1);
            end
          end
        end
        StCell: begin
          if (xfer) begin
            col_q <= col_q + CW'(1);
            idx_q <= idx_nxt;
            if (col_q == ColLast) begin
              state_q <= StCr;
              tx_data <= 8'h0D;
            end else begin
              tx_data <= cell_char(snap_q[idx_nxt]);
            end
          end
        end
        StCr: begin
          if (xfer) begin
            state_q <= StLf;
            tx_data <= 8'h0A;
          end
        end
        StLf: begin
          if (xfer) begin
            if (row_q == RowLast) begin
              state_q  <= StIdle;
              busy     <= 1'b0;
              done     <= 1'b1;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end else begin
              // idx_q already points at the first cell of the next row.
              state_q <= StCell;
              row_q   <= row_q + RW'(1);
              col_q   <= '0;
              tx_data <= cell_char(snap_q[idx_q]);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
